// File: rtl/sdram_pkg.sv
// sdram_pkg: shared command encoding, mode-register fields, error codes and timing constants
package sdram_pkg;

   typedef enum logic [2:0] {
      CMD_LOAD_MODE    = 3'b000,
      CMD_AUTO_REFRESH = 3'b001,
      CMD_PRECHARGE    = 3'b010,
      CMD_ACTIVE       = 3'b011,
      CMD_WRITE        = 3'b100,
      CMD_READ         = 3'b101,
      CMD_NOP          = 3'b111
   } cmd_e;

   localparam int MODE_BL_LSB = 0;
   localparam int MODE_BT     = 3;
   localparam int MODE_CL_LSB = 4;
   localparam int MODE_WB     = 9;
   localparam logic [9:0] MODE_RESET = 10'h020;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_IDLE_BANK = 3'd1;
   localparam logic [2:0] ERR_OPEN_BANK = 3'd2;
   localparam logic [2:0] ERR_REF_OPEN  = 3'd3;
   localparam logic [2:0] ERR_NO_MODE   = 3'd4;
   localparam logic [2:0] ERR_TIMING    = 3'd5;
   localparam logic [2:0] ERR_BAD_MODE  = 3'd6;

   localparam int T_RCD = 2;
   localparam int T_RP  = 2;
   localparam int T_RFC = 7;

   // Burst length field -> BL-1, which doubles as the wrap mask for the low column bits
   function automatic logic [2:0] bl_mask(input logic [2:0] f);
      return (f == 3'd1) ? 3'd1 : (f == 3'd2) ? 3'd3 : (f == 3'd3) ? 3'd7 : 3'd0;
   endfunction

endpackage

// File: rtl/sdram_resp_store.sv
// sdram_resp_store: 2^AW x 16 simple dual-port RAM, per-byte write enables, registered read
module sdram_resp_store #(
   parameter int AW = 14
) (
   input  logic          clk_i,
   input  logic [1:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [15:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [15:0]   rdata_o
);

   logic [15:0] mem_q [2**AW];

   // Byte-masked write and one-cycle registered read
   always_ff @(posedge clk_i) begin
      if (we_i[0]) mem_q[waddr_i][7:0] <= wdata_i[7:0];
      if (we_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: BRAM-backed SDR SDRAM device model; protocol checker built in when SDRAM_RESP_CHECK_EN is defined
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int MEM_AW   = 14,
   parameter int COL_BITS = 9,
   parameter int ROW_BITS = 13
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic [12:0] sdram_a,
   input  logic [1:0]  sdram_ba,
   input  logic        sdram_ncs,
   input  logic        sdram_nras,
   input  logic        sdram_ncas,
   input  logic        sdram_nwe,
   input  logic        sdram_dqml,
   input  logic        sdram_dqmh,
   input  logic [15:0] sdram_dq_in,
   output logic [15:0] sdram_dq_out,
   output logic        sdram_dq_oe,
   output logic        mode_valid,
   output logic        err,
   output logic [2:0]  err_code
);

   cmd_e                cmd;
   logic [9:0]          mode_q;
   logic                mode_valid_q;
   logic [3:0]          open_q, open_d;
   logic [ROW_BITS-1:0] row_q [4];
   logic                act_q, wr_q, ap_q;
   logic [1:0]          ba_q, cur_ba, we;
   logic [COL_BITS-1:0] col_q, cur_col, col_eff;
   logic [2:0]          k_q, cur_k, bl_m, lo;
   logic                new_rw, cur_wr, cur_ap, pre_hit, issue, last, cl3, wr_cmd;
   logic [MEM_AW-1:0]   addr;
   logic [15:0]         rdata, d2_q, out_d, dq_out_q;
   logic                v1_q, v2_q, out_v, dq_oe_q;
   logic [1:0]          dqm_q;
   logic                unused_mode;

   assign cmd = (sdram_ncs || {sdram_nras, sdram_ncas, sdram_nwe} == 3'b110) ? CMD_NOP
              : cmd_e'({sdram_nras, sdram_ncas, sdram_nwe});
   assign wr_cmd = cmd == CMD_WRITE;
   assign cl3 = mode_q[MODE_CL_LSB +: 3] == 3'd3;
   assign unused_mode = ^mode_q[8:7];

   // Word selection for this edge: a new READ/WRITE starts at k=0 from the pins, otherwise the running burst continues
   always_comb begin
      new_rw  = cmd == CMD_READ || wr_cmd;
      cur_ba  = new_rw ? sdram_ba : ba_q;
      cur_col = new_rw ? sdram_a[COL_BITS-1:0] : col_q;
      cur_k   = new_rw ? 3'd0 : k_q;
      cur_wr  = new_rw ? wr_cmd : wr_q;
      cur_ap  = new_rw ? sdram_a[10] : ap_q;
      pre_hit = cmd == CMD_PRECHARGE && (sdram_a[10] || sdram_ba == ba_q);
      issue   = new_rw || (act_q && !pre_hit);
      bl_m    = (cur_wr && mode_q[MODE_WB]) ? 3'd0 : bl_mask(mode_q[MODE_BL_LSB +: 3]);
      last    = cur_k == bl_m;
      lo      = mode_q[MODE_BT] ? cur_col[2:0] ^ cur_k : cur_col[2:0] + cur_k;
      col_eff = (cur_col & ~COL_BITS'(bl_m)) | COL_BITS'(lo & bl_m);
      addr    = MEM_AW'({cur_ba, row_q[cur_ba], col_eff});
      we      = (issue && cur_wr) ? ~{sdram_dqmh, sdram_dqml} : 2'b00;
      open_d  = open_q;
      if (issue && last && cur_ap) open_d[cur_ba] = 1'b0;
      if (cmd == CMD_ACTIVE) open_d[sdram_ba] = 1'b1;
      if (cmd == CMD_PRECHARGE) open_d = sdram_a[10] ? 4'b0 : open_d & ~(4'b1 << sdram_ba);
   end

   // Mode register and per-bank open-row table
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         mode_q       <= MODE_RESET;
         mode_valid_q <= 1'b0;
         open_q       <= 4'b0;
         for (int i = 0; i < 4; i++) row_q[i] <= '0;
      end else begin
         open_q <= open_d;
         if (cmd == CMD_LOAD_MODE) begin
            mode_q       <= sdram_a[9:0];
            mode_valid_q <= 1'b1;
         end
         if (cmd == CMD_ACTIVE) row_q[sdram_ba] <= sdram_a[ROW_BITS-1:0];
      end
   end

   // Burst counter and the context of the running burst
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         act_q <= 1'b0;
         wr_q  <= 1'b0;
         ap_q  <= 1'b0;
         ba_q  <= 2'd0;
         col_q <= '0;
         k_q   <= 3'd0;
      end else begin
         act_q <= issue && !last;
         if (issue) k_q <= cur_k + 3'd1;
         if (new_rw) begin
            ba_q  <= sdram_ba;
            col_q <= sdram_a[COL_BITS-1:0];
            wr_q  <= wr_cmd;
            ap_q  <= sdram_a[10];
         end
      end
   end

   sdram_resp_store #(.AW(MEM_AW)) u_store (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (addr),
      .wdata_i (sdram_dq_in),
      .raddr_i (addr),
      .rdata_o (rdata)
   );

   // CL=2 takes data straight from the RAM register; CL=3 adds one stage. A WRITE flushes everything in flight.
   assign out_v = (cl3 ? v2_q : v1_q) && !wr_cmd;
   assign out_d = cl3 ? d2_q : rdata;

   // Read pipeline; DQM is registered once so it masks the word two cycles after it is sampled
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         d2_q     <= 16'h0;
         dqm_q    <= 2'b0;
         dq_oe_q  <= 1'b0;
         dq_out_q <= 16'h0;
      end else begin
         v1_q     <= issue && !cur_wr;
         v2_q     <= v1_q && !wr_cmd;
         d2_q     <= rdata;
         dqm_q    <= {sdram_dqmh, sdram_dqml};
         dq_oe_q  <= out_v;
         dq_out_q <= out_v ? {dqm_q[1] ? 8'h0 : out_d[15:8], dqm_q[0] ? 8'h0 : out_d[7:0]} : 16'h0;
      end
   end

   assign sdram_dq_out = dq_out_q;
   assign sdram_dq_oe  = dq_oe_q;
   assign mode_valid   = mode_valid_q;

`ifdef SDRAM_RESP_CHECK_EN
   logic [1:0] bt_q [4];
   logic [2:0] rfc_q, code_q, viol;
   logic       err_q, any_cmd;

   assign any_cmd = cmd != CMD_NOP;

   // First matching violation for this command, highest priority first
   always_comb begin
      viol = (any_cmd && cmd != CMD_LOAD_MODE && !mode_valid_q) ? ERR_NO_MODE
           : (new_rw && !open_q[sdram_ba]) ? ERR_IDLE_BANK
           : (cmd == CMD_ACTIVE && open_q[sdram_ba]) ? ERR_OPEN_BANK
           : (cmd == CMD_AUTO_REFRESH && |open_q) ? ERR_REF_OPEN
           : ((any_cmd && rfc_q != 3'd0) || ((new_rw || cmd == CMD_ACTIVE) && bt_q[sdram_ba] != 2'd0)) ? ERR_TIMING
           : (cmd == CMD_LOAD_MODE && (sdram_a[2:0] > 3'd3 || !(sdram_a[6:4] inside {3'd2, 3'd3}))) ? ERR_BAD_MODE
           : ERR_NONE;
   end

   // tRCD/tRP per-bank countdowns, tRFC global countdown, sticky first error
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         rfc_q  <= 3'd0;
         err_q  <= 1'b0;
         code_q <= ERR_NONE;
         for (int i = 0; i < 4; i++) bt_q[i] <= 2'd0;
      end else begin
         rfc_q <= (cmd == CMD_AUTO_REFRESH) ? 3'(T_RFC - 1) : rfc_q - 3'(rfc_q != 3'd0);
         for (int i = 0; i < 4; i++)
            bt_q[i] <= (cmd == CMD_ACTIVE && sdram_ba == 2'(i)) ? 2'(T_RCD - 1)
                     : (cmd == CMD_PRECHARGE && (sdram_a[10] || sdram_ba == 2'(i))) ? 2'(T_RP - 1)
                     : bt_q[i] - 2'(bt_q[i] != 2'd0);
         if (!err_q && viol != ERR_NONE) begin
            err_q  <= 1'b1;
            code_q <= viol;
         end
      end
   end

   assign err      = err_q;
   assign err_code = code_q;
`else
   assign err      = 1'b0;
   assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: table-driven bench for sdram_responder plus directed interrupt, reset and checker sequences
module tb_sdram_responder;

   localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
   localparam logic [2:0] PRE = 3'b010, LMR = 3'b000;
`ifdef SDRAM_RESP_CHECK_EN
   localparam logic       ERR_EXP  = 1'b1;
   localparam logic [2:0] CODE_EXP = 3'd1;
`else
   localparam logic       ERR_EXP  = 1'b0;
   localparam logic [2:0] CODE_EXP = 3'd0;
`endif

   logic        clk = 1'b0;
   logic        init_n, ncs, nras, ncas, nwe, dqml, dqmh;
   logic [12:0] a;
   logic [1:0]  ba;
   logic [15:0] dq_in, dq_out;
   logic        dq_oe, mode_valid, err;
   logic [2:0]  err_code;

   always #5 clk = ~clk;

   sdram_responder #(.MEM_AW(14), .COL_BITS(9), .ROW_BITS(13)) dut (
      .clk          (clk),
      .init_n       (init_n),
      .sdram_a      (a),
      .sdram_ba     (ba),
      .sdram_ncs    (ncs),
      .sdram_nras   (nras),
      .sdram_ncas   (ncas),
      .sdram_nwe    (nwe),
      .sdram_dqml   (dqml),
      .sdram_dqmh   (dqmh),
      .sdram_dq_in  (dq_in),
      .sdram_dq_out (dq_out),
      .sdram_dq_oe  (dq_oe),
      .mode_valid   (mode_valid),
      .err          (err),
      .err_code     (err_code)
   );

   typedef struct {
      logic [2:0]  c;
      logic [1:0]  b;
      logic [12:0] a;
      logic [15:0] d;
      logic [1:0]  m;
      logic        oe;
      logic [15:0] q;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   oe_cnt;

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   // One command per clock: drive at the falling edge, return just after the sampling edge
   task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] aa,
                        input logic [15:0] d, input logic [1:0] m);
      @(negedge clk);
      {nras, ncas, nwe} = c;
      ncs = 1'b0;
      ba = b;
      a = aa;
      dq_in = d;
      {dqmh, dqml} = m;
      @(posedge clk);
      #1;
   endtask

   task automatic p(input logic [2:0] c, input logic [1:0] b, input logic [12:0] aa,
                    input logic [15:0] d, input logic [1:0] m, input logic oe, input logic [15:0] q);
      tbl.push_back('{c, b, aa, d, m, oe, q});
   endtask

   task automatic r(input logic [15:0] q);
      p(NOP, 2'd0, 13'h0, 16'h0, 2'b00, 1'b1, q);
   endtask

   task automatic z();
      p(NOP, 2'd0, 13'h0, 16'h0, 2'b00, 1'b0, 16'h0);
   endtask

   initial begin
      init_n = 1'b0;
      ncs = 1'b0;
      {nras, ncas, nwe} = NOP;
      a = '0;
      ba = '0;
      dq_in = '0;
      {dqmh, dqml} = 2'b00;

      // BL4 CL2 sequential: write, aligned read, wrapped read, gapless back-to-back read
      p(LMR, 2'd0, 13'h022, 16'h0, 2'b00, 1'b0, 16'h0);
      z();
      p(ACT, 2'd1, 13'h005, 16'h0, 2'b00, 1'b0, 16'h0);
      z(); z();
      p(WR,  2'd1, 13'h010, 16'h1111, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h2222, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h3333, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h4444, 2'b00, 1'b0, 16'h0);
      p(RD,  2'd1, 13'h010, 16'h0, 2'b00, 1'b0, 16'h0);
      r(16'h1111); r(16'h2222); r(16'h3333); r(16'h4444);
      z();
      p(RD,  2'd1, 13'h012, 16'h0, 2'b00, 1'b0, 16'h0);
      r(16'h3333); r(16'h4444); r(16'h1111);
      p(RD,  2'd1, 13'h010, 16'h0, 2'b00, 1'b1, 16'h2222);
      r(16'h1111); r(16'h2222); r(16'h3333); r(16'h4444);
      z();
      // Interleaved mode
      p(LMR, 2'd0, 13'h02A, 16'h0, 2'b00, 1'b0, 16'h0);
      z();
      p(RD,  2'd1, 13'h011, 16'h0, 2'b00, 1'b0, 16'h0);
      r(16'h2222); r(16'h1111); r(16'h4444); r(16'h3333);
      z();
      // Write byte mask: low byte of word 1 kept
      p(LMR, 2'd0, 13'h022, 16'h0, 2'b00, 1'b0, 16'h0);
      p(WR,  2'd1, 13'h010, 16'h1111, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'hABCD, 2'b01, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h3333, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h4444, 2'b00, 1'b0, 16'h0);
      p(RD,  2'd1, 13'h010, 16'h0, 2'b00, 1'b0, 16'h0);
      r(16'h1111); r(16'hAB22); r(16'h3333); r(16'h4444);
      z();
      // Read DQM, two-cycle latency: masked word driven as zero
      p(RD,  2'd1, 13'h010, 16'h0, 2'b00, 1'b0, 16'h0);
      p(NOP, 2'd0, 13'h000, 16'h0, 2'b11, 1'b1, 16'h1111);
      r(16'h0000); r(16'h3333); r(16'h4444);
      z();
      // PRECHARGE one cycle into a CL2 read: only CL-1 = 1 word escapes
      p(RD,  2'd1, 13'h010, 16'h0, 2'b00, 1'b0, 16'h0);
      p(PRE, 2'd1, 13'h000, 16'h0, 2'b00, 1'b1, 16'h1111);
      z();
      p(ACT, 2'd1, 13'h005, 16'h0, 2'b00, 1'b0, 16'h0);
      z(); z();

      #12;
      check("reset dq_oe", 16'(dq_oe), 16'h0);
      check("reset dq_out", dq_out, 16'h0);
      check("reset mode_valid", 16'(mode_valid), 16'h0);
      check("reset err", 16'(err), 16'h0);
      check("reset err_code", 16'(err_code), 16'h0);
      @(negedge clk);
      init_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].m);
         check($sformatf("row%0d dq_oe", i), 16'(dq_oe), 16'(tbl[i].oe));
         if (tbl[i].oe) check($sformatf("row%0d dq_out", i), dq_out, tbl[i].q);
      end
      check("mode_valid after LMR", 16'(mode_valid), 16'h1);
      check("err after legal traffic", 16'(err), 16'h0);
      check("err_code after legal traffic", 16'(err_code), 16'h0);

      // CL3 read cancelled by a write one cycle later
      drive(LMR, 2'd0, 13'h032, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      drive(RD, 2'd1, 13'h010, 16'h0, 2'b00);
      oe_cnt = int'(dq_oe);
      drive(WR, 2'd1, 13'h014, 16'h5555, 2'b00);
      check("oe low at write edge", 16'(dq_oe), 16'h0);
      oe_cnt += int'(dq_oe);
      drive(NOP, 2'd0, 13'h000, 16'h6666, 2'b00);
      oe_cnt += int'(dq_oe);
      drive(NOP, 2'd0, 13'h000, 16'h7777, 2'b00);
      oe_cnt += int'(dq_oe);
      drive(NOP, 2'd0, 13'h000, 16'h8888, 2'b00);
      oe_cnt += int'(dq_oe);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      oe_cnt += int'(dq_oe);
      check("read words around cancel <= 1", 16'(oe_cnt <= 1), 16'h1);
      drive(RD, 2'd1, 13'h014, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      check("cl3 oe before first word", 16'(dq_oe), 16'h0);
      for (int k = 0; k < 4; k++) begin
         drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
         check($sformatf("cl3 word%0d oe", k), 16'(dq_oe), 16'h1);
         check($sformatf("cl3 word%0d data", k), dq_out, 16'h5555 + 16'(k) * 16'h1111);
      end
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      check("cl3 oe after burst", 16'(dq_oe), 16'h0);

      // Asynchronous reset in the middle of a read burst
      drive(LMR, 2'd0, 13'h022, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      drive(RD, 2'd1, 13'h010, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      check("pre-reset oe", 16'(dq_oe), 16'h1);
      check("pre-reset data", dq_out, 16'h1111);
      #2;
      init_n = 1'b0;
      #1;
      check("async reset dq_oe", 16'(dq_oe), 16'h0);
      check("async reset dq_out", dq_out, 16'h0);
      check("async reset mode_valid", 16'(mode_valid), 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      init_n = 1'b1;
      drive(LMR, 2'd0, 13'h022, 16'h0, 2'b00);
      check("mode_valid after re-init", 16'(mode_valid), 16'h1);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      drive(ACT, 2'd1, 13'h005, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
      drive(RD, 2'd1, 13'h014, 16'h0, 2'b00);
      for (int k = 0; k < 4; k++) begin
         drive(NOP, 2'd0, 13'h000, 16'h0, 2'b00);
         check($sformatf("post-reset word%0d oe", k), 16'(dq_oe), 16'h1);
         check($sformatf("post-reset word%0d data", k), dq_out, 16'h5555 + 16'(k) * 16'h1111);
      end

      // Protocol checker: READ to idle bank, then ACTIVE to an open bank keeps the first code
      drive(RD, 2'd2, 13'h000, 16'h0, 2'b00);
      check("idle-bank read err", 16'(err), 16'(ERR_EXP));
      check("idle-bank read err_code", 16'(err_code), 16'(CODE_EXP));
      drive(ACT, 2'd1, 13'h005, 16'h0, 2'b00);
      check("err sticky", 16'(err), 16'(ERR_EXP));
      check("err_code keeps first", 16'(err_code), 16'(CODE_EXP));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
